// File: rtl/wb_sched_pkg.sv
// Shared types and constants for the dual-lane writeback scheduler.
package wb_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  localparam logic [4:0] REGZERO      = 5'd0;
  localparam int         CNTW_DEFAULT = 32;

endpackage

// File: rtl/wb_lane_sel.sv
// Per-lane writeback qualifier: decides whether the lane writes and what value it carries.
module wb_lane_sel
  import wb_sched_pkg::*;
(
  input  logic        regwrite_i,
  input  logic        memtoreg_i,
  input  logic [31:0] readdata_i,
  input  logic [31:0] aluout_i,
  input  logic [4:0]  writereg_i,
  output logic        valid_o,
  output logic [31:0] result_o
);

  // Writes to r0 are discarded so the register file never sees address 0.
  assign valid_o  = regwrite_i && (writereg_i != REGZERO);
  assign result_o = memtoreg_i ? readdata_i : aluout_i;

endmodule

// File: rtl/wb_sched.sv
// Serialises two writeback lanes onto a single register-file write port,
// splitting distinct-destination pairs over two cycles by stalling MEM/WB.
module wb_sched
  import wb_sched_pkg::*;
#(
  parameter int CNTW = CNTW_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            regwritew,
  input  logic            regwritew2,
  input  logic            memtoregw,
  input  logic            memtoregw2,
  input  logic [31:0]     readdataw,
  input  logic [31:0]     readdataw2,
  input  logic [31:0]     aluoutw,
  input  logic [31:0]     aluoutw2,
  input  logic [4:0]      writeregw,
  input  logic [4:0]      writeregw2,
  input  logic            stallext,
  output logic            we,
  output logic [4:0]      wa,
  output logic [31:0]     wd,
  output logic            stallw,
  output logic            stallw2,
  output logic [CNTW-1:0] retirecnt,
  output logic [15:0]     conflictcnt
);

  logic        valid1, valid2;
  logic [31:0] result1, result2;

  state_t          state_q, state_d;
  logic [CNTW-1:0] retire_q;
  logic [15:0]     conflict_q;
  logic            conflict_d;

  wb_lane_sel u_lane1 (
    .regwrite_i (regwritew),
    .memtoreg_i (memtoregw),
    .readdata_i (readdataw),
    .aluout_i   (aluoutw),
    .writereg_i (writeregw),
    .valid_o    (valid1),
    .result_o   (result1)
  );

  wb_lane_sel u_lane2 (
    .regwrite_i (regwritew2),
    .memtoreg_i (memtoregw2),
    .readdata_i (readdataw2),
    .aluout_i   (aluoutw2),
    .writereg_i (writeregw2),
    .valid_o    (valid2),
    .result_o   (result2)
  );

  always_comb begin
    state_d    = state_q;
    we         = 1'b0;
    wa         = REGZERO;
    wd         = 32'd0;
    stallw     = 1'b0;
    stallw2    = 1'b0;
    conflict_d = 1'b0;
    if (!resetn) begin
      state_d = IDLE;
    end else if (stallext) begin
      stallw  = 1'b1;
      stallw2 = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid1 && valid2) begin
            if (writeregw == writeregw2) begin
              // Younger lane overwrites the older one; only one write needed.
              we         = 1'b1;
              wa         = writeregw2;
              wd         = result2;
              conflict_d = 1'b1;
            end else begin
              we      = 1'b1;
              wa      = writeregw;
              wd      = result1;
              stallw  = 1'b1;
              stallw2 = 1'b1;
              state_d = SECOND;
            end
          end else if (valid1) begin
            we = 1'b1;
            wa = writeregw;
            wd = result1;
          end else if (valid2) begin
            we = 1'b1;
            wa = writeregw2;
            wd = result2;
          end
        end
        SECOND: begin
          // MEM/WB was held, so lane 2 still presents the deferred write.
          we      = valid2;
          wa      = valid2 ? writeregw2 : REGZERO;
          wd      = result2;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      retire_q   <= '0;
      conflict_q <= '0;
    end else begin
      state_q <= state_d;
      if (we) retire_q <= retire_q + CNTW'(1);
      if (conflict_d) conflict_q <= conflict_q + 16'd1;
    end
  end

  assign retirecnt   = retire_q;
  assign conflictcnt = conflict_q;

endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning:
  clk  in  1  sole clock, rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 regwritew, regwritew2  in  1 each  lane 1 / lane 2 register-write enable from the MEM/WB register.
REQ-004 memtoregw, memtoregw2  in  1 each  result select: 1 selects readdata, 0 selects aluout.
REQ-005 readdataw, readdataw2, aluoutw, aluoutw2  in  32 each  lane load data / ALU result.
REQ-006 writeregw, writeregw2  in  5 each  lane destination register.
REQ-007 stallext  in  1  external writeback stall from the hazard unit.
REQ-008 we  out  1  register-file write enable; the file has a single write port.
REQ-009 wa  out  5  write address.
REQ-010 wd  out  32  write data.
REQ-011 stallw, stallw2  out  1 each  hold requests to the MEM/WB register, one per lane.
REQ-012 retirecnt  out  32  count of register writes performed.
REQ-013 conflictcnt  out  16  count of same-destination squashes.
REQ-014 Parameter CNTW, default 32, sets the width of retirecnt.

Function
REQ-020 Lane N SHALL be valid when its regwrite is 1 and its writereg is not 0.
REQ-021 Lane N result SHALL be readdata when its memtoreg is 1, otherwise aluout.
REQ-022 Lane 1 is older and lane 2 is younger; on a same-destination conflict the younger lane SHALL win.
REQ-023 FSM states SHALL be IDLE and SECOND; the reset state SHALL be IDLE.
REQ-024 In IDLE with no valid lane: we=0, no stall, the FSM stays in IDLE.
REQ-025 In IDLE with exactly one valid lane: that lane is written in the same cycle (we, wa, wd combinational), no stall, the FSM stays in IDLE.
REQ-026 In IDLE with both lanes valid and equal writereg: only lane 2 is written, lane 1 is squashed, conflictcnt increments, no stall, the FSM stays in IDLE.
REQ-027 In IDLE with both lanes valid and different writereg: lane 1 is written, stallw and stallw2 are both driven 1, and the FSM moves to SECOND.
REQ-028 In SECOND the MEM/WB inputs are held by the stall: lane 2 is written, the stalls drop to 0, and the FSM returns to IDLE.
REQ-029 stallext=1 takes priority in any state: we=0, stallw=stallw2=1, the FSM state holds, and both counters hold.
REQ-030 retirecnt SHALL increment by 1 on every cycle with we=1 and wrap modulo 2^CNTW; conflictcnt SHALL wrap modulo 2^16.
REQ-031 Write latency SHALL be 0 cycles for the first write and 1 extra cycle for the second write of a split pair.
REQ-032 The block SHALL never assert we with wa=0.

Reset
REQ-040 While resetn=0 at a rising edge: the FSM enters IDLE and retirecnt=0, conflictcnt=0.
REQ-041 While resetn=0: we=0, stallw=stallw2=0, regardless of inputs.
REQ-042 A reset asserted in SECOND SHALL drop the pending lane 2 write with no partial write.

Structure
REQ-050 Package wb_sched_pkg SHALL hold the FSM state typedef (IDLE, SECOND), the constant REGZERO=5'd0, and the default CNTW.
REQ-051 One sub-module, wb_lane_sel, SHALL be instantiated once per lane and produce that lane's valid bit and 32-bit result; the rest of the design (FSM, muxing, counters) SHALL reside in wb_sched.

Verification
REQ-060 Lane 1 alone valid (regwritew=1, writeregw=5, memtoregw=0, aluoutw=0x11) -> same cycle we=1, wa=5, wd=0x11, no stall, retirecnt=1.
REQ-061 Both lanes valid (lane 1 to reg 3 with readdata 0xAA, lane 2 to reg 7 with aluout 0xBB) -> cycle 0 writes wa=3, wd=0xAA with stallw=stallw2=1; cycle 1 writes wa=7, wd=0xBB with stalls 0; retirecnt increases by 2.
REQ-062 Both lanes valid to reg 9 (lane 1 0x1, lane 2 0x2) -> a single write wa=9, wd=0x2, conflictcnt=1, no stall.
REQ-063 A lane with writereg=0 and regwrite=1, paired with a lane 2 write to reg 4 -> only reg 4 is written, no stall.
REQ-064 stallext=1 for 3 cycles during SECOND -> we=0 and both stalls 1 for those 3 cycles; after release, lane 2 is written exactly once.
REQ-065 resetn=0 during SECOND -> the next cycle is in IDLE with counters 0, and the pending lane 2 write never appears.
